// File: rtl/decoder_256b_pipe_pkg.sv
// decoder_256b_pipe_pkg: shared index width and op encoding for the one-hot decoder
package decoder_256b_pipe_pkg;
   localparam int IDX_W = 8;
   typedef enum logic [1:0] {
      OP_DECODE = 2'd0,
      OP_SET    = 2'd1,
      OP_CLR    = 2'd2,
      OP_TOGGLE = 2'd3
   } op_e;
endpackage

// File: rtl/decoder_256b_pipe_dec32.sv
// decoder_32b: combinational 5->32 one-hot with enable
module decoder_32b (
   input  logic        en_i,
   input  logic [4:0]  sel_i,
   output logic [31:0] y_o
);
   assign y_o = en_i ? 32'(1) << sel_i : '0;
endmodule

// File: rtl/decoder_256b_pipe.sv
// decoder_256b_pipe: two-stage 8->256 one-hot decoder with a per-index occupancy mask
module decoder_256b_pipe
   import decoder_256b_pipe_pkg::*;
#(
   parameter logic [255:0] MASK_RST = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_idx,
   input  logic [1:0]       in_op,
   input  logic             in_en,
   input  logic             mask_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [255:0]     out_onehot,
   output logic [255:0]     out_mask,
   output logic             out_hit
);
   logic         s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, adv1, adv2;
   logic [4:0]   lo_q, lo_d;
   op_e          op_q, op_d;
   logic         en_q, en_d, hit_q, hit_d;
   logic [7:0]   grp_q, grp_d;
   logic [255:0] h, upd, onehot_q, onehot_d, mask_q, mask_d;

   assign adv2     = s1_valid_q & (~s2_valid_q | out_ready);
   assign in_ready = ~s1_valid_q | adv2;
   assign adv1     = in_valid & in_ready;

   for (genvar g = 0; g < 8; g++) begin : g_dec
      decoder_32b u_dec (
         .en_i  (en_q & grp_q[g]),
         .sel_i (lo_q),
         .y_o   (h[32*g +: 32])
      );
   end

   always_comb begin
      s1_valid_d = adv1 | (s1_valid_q & ~adv2);
      s2_valid_d = adv2 | (s2_valid_q & ~out_ready);
      lo_d       = adv1 ? in_idx[4:0] : lo_q;
      op_d       = adv1 ? op_e'(in_op) : op_q;
      en_d       = adv1 ? in_en : en_q;
      grp_d      = adv1 ? (in_en ? 8'(1) << in_idx[7:5] : '0) : grp_q;
      upd        = op_q == OP_SET    ? mask_q | h :
                   op_q == OP_CLR    ? mask_q & ~h :
                   op_q == OP_TOGGLE ? mask_q ^ h : mask_q;
      onehot_d   = adv2 ? h : onehot_q;
      hit_d      = adv2 ? |(mask_q & h) : hit_q;
      // a synchronous clear wins over the update of a beat leaving S1 on the same edge
      mask_d     = mask_clr ? '0 : adv2 ? upd : mask_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         lo_q       <= '0;
         op_q       <= OP_DECODE;
         en_q       <= 1'b0;
         grp_q      <= '0;
         onehot_q   <= '0;
         hit_q      <= 1'b0;
         mask_q     <= MASK_RST;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         lo_q       <= lo_d;
         op_q       <= op_d;
         en_q       <= en_d;
         grp_q      <= grp_d;
         onehot_q   <= onehot_d;
         hit_q      <= hit_d;
         mask_q     <= mask_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_onehot = onehot_q;
   assign out_mask   = mask_q;
   assign out_hit    = hit_q;
endmodule
